// File: rtl/f_seq_priority_encoder.sv
// f_seq_priority_encoder: chunked MSB-first scan returning highest-set-bit position, zero flag and normalising shift.
// Define F_PENC_NORM_EN to add the out_mant port carrying the normalised operand.
module f_seq_priority_encoder #(
   parameter int WIDTH = 23,
   parameter int CHUNK = 8,
   parameter int POS_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [POS_W-1:0] out_pos,
   output logic [POS_W-1:0] out_shamt,
   output logic             out_zero,
   output logic             busy
`ifdef F_PENC_NORM_EN
   ,
   output logic [WIDTH-1:0] out_mant
`endif
);
   localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
   localparam int PTR_W = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] opnd;
   logic [PTR_W-1:0] ptr;
   logic [POS_W-1:0] hit_pos, shamt_nx;
   logic hit, last, accept, finish;
   // in_ready is forced low while reset is held, even though the state already reads IDLE
   assign in_ready = rst_n && (state == IDLE || (state == DONE && out_ready));
   assign accept = in_valid && in_ready;
   assign out_valid = state == DONE;
   assign busy = state != IDLE;
   assign last = ptr == '0;
   assign finish = state == SCAN && (hit || last);
   assign shamt_nx = POS_W'(WIDTH) - hit_pos;
   always_comb begin
      hit = 1'b0;
      hit_pos = '0;
      for (int i = 0; i < WIDTH; i++)
         if (PTR_W'(i / CHUNK) == ptr && opnd[i]) begin
            hit = 1'b1;
            hit_pos = POS_W'(i + 1);
         end
   end
   always_comb begin
      state_nx = state;
      state_nx = accept ? SCAN : finish ? DONE : (state == DONE && out_ready) ? IDLE : state;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         opnd <= '0;
         ptr <= '0;
         out_pos <= '0;
         out_shamt <= '0;
         out_zero <= 1'b0;
`ifdef F_PENC_NORM_EN
         out_mant <= '0;
`endif
      end else begin
         state <= state_nx;
         if (accept) begin
            opnd <= in_a;
            ptr <= PTR_W'(NCHUNK - 1);
         end else if (state == SCAN && !hit && !last)
            ptr <= ptr - 1'b1;
         if (finish) begin
            out_pos <= hit_pos;
            out_shamt <= shamt_nx;
            out_zero <= !hit;
`ifdef F_PENC_NORM_EN
            out_mant <= opnd << shamt_nx;
`endif
         end
      end
endmodule

// File: tb/tb_f_seq_priority_encoder.sv
// tb_f_seq_priority_encoder: scoreboard bench running CHUNK=8, 1 and 23 side by side against an MSB reference model.
module tb_f_seq_priority_encoder;
   localparam int W = 23;
   localparam int PW = $clog2(W + 1);
   localparam int NV = 6 + W + 40;
   typedef struct {
      logic [W-1:0] a;
      int acc;
      int j;
      int pos;
   } exp_t;
   logic clk, rst_n, rt_go;
   int cyc = 0;
   int passed = 0;
   int total = 0;
   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      total++;
      if (a === e) passed++;
      else $display("FAIL %s: got %0h expected %0h", n, a, e);
   endtask
   function automatic exp_t model(input logic [W-1:0] a, input int ch, input int acc);
      exp_t e;
      int nch;
      nch = (W + ch - 1) / ch;
      e.a = a;
      e.acc = acc;
      e.pos = 0;
      for (int b = W - 1; b >= 0; b--)
         if (a[b] && e.pos == 0) e.pos = b + 1;
      e.j = e.pos == 0 ? nch : nch - (e.pos - 1) / ch;
      return e;
   endfunction
   function automatic logic [W-1:0] opnd(input int i);
      logic [31:0] r;
      case (i)
         0: return 23'h400000;
         1: return 23'h000001;
         2: return 23'h000100;
         3: return 23'h000000;
         4: return 23'h00F000;
         5: return 23'h000002;
         default: begin
            if (i < 6 + W) return W'(1) << (i - 6);
            r = $urandom & ((32'h1 << $urandom_range(0, W)) - 1);
            return W'(r);
         end
      endcase
   endfunction
   for (genvar c = 0; c < 3; c++) begin : g
      localparam int CH = c == 0 ? 8 : c == 1 ? 1 : 23;
      logic in_valid, in_ready, out_valid, out_ready, out_zero, busy, done, done2;
      logic [W-1:0] in_a;
      logic [PW-1:0] out_pos, out_shamt;
`ifdef F_PENC_NORM_EN
      logic [W-1:0] out_mant;
`endif
      exp_t q[$];
      bit seen;
      int idx;
      int scnt;
      f_seq_priority_encoder #(.WIDTH(W), .CHUNK(CH)) dut (
         .clk(clk),
         .rst_n(rst_n),
         .in_valid(in_valid),
         .in_ready(in_ready),
         .in_a(in_a),
         .out_valid(out_valid),
         .out_ready(out_ready),
         .out_pos(out_pos),
         .out_shamt(out_shamt),
         .out_zero(out_zero),
         .busy(busy)
`ifdef F_PENC_NORM_EN
         ,
         .out_mant(out_mant)
`endif
      );
      always @(negedge clk) begin
         if (!rst_n) begin
            q.delete();
            seen = 0;
         end else begin
            if (out_valid) begin
               if (q.size() == 0) chk($sformatf("spurious_valid_c%0d", CH), out_valid, 0);
               else begin
                  if (!seen) chk($sformatf("latency_c%0d_a%0h", CH, q[0].a), cyc, q[0].acc + q[0].j + 1);
                  seen = 1;
                  chk($sformatf("pos_c%0d_a%0h", CH, q[0].a), out_pos, q[0].pos);
                  chk($sformatf("shamt_c%0d_a%0h", CH, q[0].a), out_shamt, W - q[0].pos);
                  chk($sformatf("zero_c%0d_a%0h", CH, q[0].a), out_zero, q[0].pos == 0);
`ifdef F_PENC_NORM_EN
                  chk($sformatf("mant_c%0d_a%0h", CH, q[0].a), out_mant, W'(q[0].a << (W - q[0].pos)));
`endif
                  if (!out_ready) chk($sformatf("stall_in_ready_c%0d", CH), in_ready, 0);
                  else begin
                     void'(q.pop_front());
                     seen = 0;
                  end
               end
            end
            if (in_valid && in_ready) q.push_back(model(in_a, CH, cyc));
         end
      end
      initial begin
         out_ready = 0;
         scnt = 0;
         forever begin
            @(posedge clk);
            #1;
            if (out_valid && q.size() > 0 && q[0].a == 23'h00F000 && scnt < 5) begin
               out_ready = 0;
               scnt++;
            end else out_ready = idx < 6 ? 1'b1 : $urandom_range(0, 3) != 0;
         end
      end
      initial begin
         bit tk;
         idx = 0;
         in_valid = 0;
         in_a = '0;
         done = 0;
         done2 = 0;
         #3;
         chk($sformatf("rst_in_ready_c%0d", CH), in_ready, 0);
         chk($sformatf("rst_out_valid_c%0d", CH), out_valid, 0);
         chk($sformatf("rst_busy_c%0d", CH), busy, 0);
         @(posedge rst_n);
         @(negedge clk);
         chk($sformatf("idle_in_ready_c%0d", CH), in_ready, 1);
         chk($sformatf("rst_pos_c%0d", CH), {out_pos, out_shamt, out_zero}, 0);
         for (int k = 0; k < 8000 && idx < NV; k++) begin
            @(negedge clk);
            tk = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (tk) begin
               in_valid = 0;
               idx++;
            end
            if (!in_valid) begin
               if (idx < NV && (idx < 6 || $urandom_range(0, 3) != 0)) begin
                  in_a = opnd(idx);
                  in_valid = 1;
               end else in_a = W'($urandom);
            end
         end
         chk($sformatf("stim_done_c%0d", CH), idx, NV);
         in_valid = 0;
         for (int k = 0; k < 400 && q.size() > 0; k++) @(negedge clk);
         chk($sformatf("drain_c%0d", CH), q.size(), 0);
         done = 1;
         wait (rt_go);
         @(posedge clk);
         #1;
         in_valid = 1;
         in_a = 23'h000001;
         @(posedge clk);
         #1;
         in_valid = 0;
         @(negedge rst_n);
         #1;
         chk($sformatf("abort_out_valid_c%0d", CH), out_valid, 0);
         chk($sformatf("abort_pos_c%0d", CH), out_pos, 0);
         chk($sformatf("abort_shamt_c%0d", CH), out_shamt, 0);
         chk($sformatf("abort_zero_c%0d", CH), out_zero, 0);
         chk($sformatf("abort_busy_c%0d", CH), busy, 0);
         chk($sformatf("abort_in_ready_c%0d", CH), in_ready, 0);
         @(posedge rst_n);
         @(negedge clk);
         chk($sformatf("release_in_ready_c%0d", CH), in_ready, 1);
         repeat (30) @(negedge clk);
         chk($sformatf("no_stale_valid_c%0d", CH), out_valid, 0);
         chk($sformatf("no_stale_busy_c%0d", CH), busy, 0);
         done2 = 1;
      end
   end
   initial begin
      rst_n = 0;
      rt_go = 0;
      #23 rst_n = 1;
      for (int k = 0; k < 30000 && !(g[0].done && g[1].done && g[2].done); k++) @(posedge clk);
      chk("stim_phase_done", {g[0].done, g[1].done, g[2].done}, 3'b111);
      @(posedge clk);
      #1 rt_go = 1;
      repeat (3) @(posedge clk);
      #3 rst_n = 0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1;
      for (int k = 0; k < 200 && !(g[0].done2 && g[1].done2 && g[2].done2); k++) @(posedge clk);
      chk("abort_phase_done", {g[0].done2, g[1].done2, g[2].done2}, 3'b111);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/f_seq_priority_encoder.md
Name: f_seq_priority_encoder

Overview:
- Parametrised, multi-cycle successor to the FPU's 23-bit mantissa priority encoder, for mantissa normalisation in the float datapath.
- Scans a WIDTH-bit operand MSB-first, CHUNK bits per cycle, with early exit on the first set bit.
- Returns the 1-based position of the highest set bit, the zero flag and the left-shift amount needed for normalisation.
- Valid/ready handshakes on both sides, so the block can sit between pipeline stages of the add/normalise path.

Parameters:
- WIDTH, 23, operand width in bits (legal range 2..64).
- CHUNK, 8, bits examined per scan cycle (legal range 1..WIDTH).
- POS_W, $clog2(WIDTH+1), width of the pos and shamt outputs (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand.
- in_a  input  WIDTH  operand.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_pos  output  POS_W  index+1 of highest set bit; 0 if operand is zero.
- out_shamt  output  POS_W  WIDTH - out_pos; equals WIDTH for a zero operand.
- out_zero  output  1  operand was all zeros.
- busy  output  1  state is not IDLE.

Behaviour:
- NCHUNK = ceil(WIDTH/CHUNK). Chunk k covers bits min(WIDTH-1, (k+1)*CHUNK-1) down to k*CHUNK. The top chunk may be partial (e.g. WIDTH=23, CHUNK=8: chunks are [22:16], [15:8], [7:0]).
- Reset (async assert, sync to clk on release) sets:
  - state=IDLE
  - out_valid=0, out_pos=0, out_shamt=0, out_zero=0
  - operand register=0, chunk pointer=0
  - in_ready=0 while rst_n is low, then 1 in IDLE.
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture in_a, set ptr=NCHUNK-1, go to SCAN.
  - SCAN: in_ready=0. Examine chunk[ptr] of the captured operand.
    - Any bit set: out_pos = ptr*CHUNK + (local MSB index) + 1, out_zero=0, go to DONE.
    - No bit set and ptr==0: out_pos=0, out_zero=1, go to DONE.
    - Otherwise ptr decrements and the block stays in SCAN.
  - DONE: out_valid=1. Outputs are held stable while out_ready=0.
    - When out_ready=1, the result is consumed.
    - If in_valid=1 in the same cycle: capture in_a and go directly to SCAN (in_ready = out_ready in DONE).
    - Otherwise go to IDLE.
- Results are registered: out_pos, out_shamt and out_zero are updated on the edge that leaves SCAN and are constant for the whole DONE residency.
- Latency, with input accepted at edge T and the hit in the j-th chunk examined (1..NCHUNK): out_valid is high from T+j+1. A zero operand takes j=NCHUNK.
- Throughput:
  - With out_ready held high, one result every j+1 cycles (back-to-back via DONE→SCAN).
  - Otherwise one result every j+2 cycles (via IDLE).
- Arithmetic: out_shamt is computed in POS_W bits and never underflows (out_pos ≤ WIDTH).
- in_a is ignored outside an accept cycle. in_valid while in SCAN is not captured, and upstream must hold it.
- Degenerate case CHUNK=WIDTH: single-cycle scan, out_valid at T+2 for every operand.
- rst_n asserted mid-SCAN or mid-DONE aborts immediately. No result is emitted after release.

Optional Feature:
- Macro: F_PENC_NORM_EN.
- Defined: adds output port out_mant (WIDTH bits), equal to the captured operand << out_shamt (bit WIDTH-1 set unless zero).
  - Registered in the same cycle as out_pos and held through DONE.
  - Reset value 0. A zero operand gives out_mant=0.
- Undefined: the port and its shift logic are absent. All other behaviour is identical.

Test Plan:
- WIDTH=23, CHUNK=8, in_a=23'h400000 accepted at T, out_ready=1 -> out_valid at T+2, out_pos=23, out_shamt=0, out_zero=0 (out_mant=23'h400000 with F_PENC_NORM_EN).
- in_a=23'h000001 -> out_valid at T+4, out_pos=1, out_shamt=22 (out_mant=23'h400000); in_a=23'h000100 -> T+3, out_pos=9, out_shamt=14.
- in_a=0 -> out_valid at T+4, out_pos=0, out_zero=1, out_shamt=23 (out_mant=0).
- Backpressure:
  - Result for 23'h00F000 (out_pos=16) with out_ready=0 for 5 cycles -> outputs stable and in_ready=0 throughout.
  - out_ready=1 with in_valid=1 (in_a=23'h000002) -> same-edge accept, next result out_pos=2 at 3 edges after the accept.
- rst_n pulsed low mid-SCAN for in_a=23'h000001 -> out_valid, out_pos, out_zero, out_shamt and busy all 0 immediately; after release in_ready=1 and no stale result appears.
- Sweep CHUNK=1 and CHUNK=23 with random plus walking-one operands -> out_pos matches a software MSB model and latency equals the formula for every operand.
